// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the digit-count helper.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

  // One digit per bit pair plus one more so an unsigned top bit is recoded correctly.
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: one overlapping multiplier triplet to a signed digit.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output digit_t     digit
);

  always_comb begin
    digit = ZERO;
    unique case (triplet)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, valid/ready on
// both sides. Operand signedness is chosen per transaction.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N  = booth_digits(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + 4;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [WIDTH+2:0] a_sh;   // extended multiplier with the implicit 0 below the LSB
  logic [AW-1:0]  b_sh;     // extended multiplicand, pre-shifted by 2i for digit i
  logic [AW-1:0]  acc;
  logic [AW-1:0]  pp;
  digit_t         digit;
  logic           accept;
  logic           last;
  logic           unused_acc_hi;

  booth_digit_enc u_enc (
    .triplet (a_sh[2:0]),
    .digit   (digit)
  );

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(N - 1));

  always_comb begin
    pp = '0;
    unique case (digit)
      POS1:    pp = b_sh;
      POS2:    pp = b_sh << 1;
      NEG1:    pp = -b_sh;
      NEG2:    pp = -(b_sh << 1);
      default: pp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
    end else if (flush) begin
      cnt <= '0;
      acc <= '0;
    end else if (state == IDLE && accept) begin
      cnt  <= '0;
      acc  <= '0;
      a_sh <= {{2{a_signed & a[WIDTH-1]}}, a, 1'b0};
      b_sh <= {{(WIDTH+4){b_signed & b[WIDTH-1]}}, b};
    end else if (state == BUSY) begin
      acc  <= acc + pp;
      a_sh <= {{2{a_sh[WIDTH+2]}}, a_sh[WIDTH+2:2]};
      b_sh <= b_sh << 2;
      cnt  <= cnt + 1'b1;
    end
  end

  assign in_ready      = (state == IDLE);
  assign busy          = (state == BUSY);
  assign out_valid     = (state == DONE);
  assign product       = acc[2*WIDTH-1:0];
  // Guard bits only matter inside the running sum; the result is taken modulo 2^(2*WIDTH).
  assign unused_acc_hi = ^acc[AW-1:2*WIDTH];

endmodule
